// File: rtl/execute_muldiv_if.sv
// Operand/result bundle between the Decode->Execute pipeline register, the RV32M
// mul/div unit and the Execute/Memory result mux.
interface execute_muldiv_if #(
    parameter int XLEN = 32
) ();
    logic [5:0]      ALU_Control_In;
    logic [XLEN-1:0] read_Data_1_In;
    logic [XLEN-1:0] read_Data_2_In;
    logic [4:0]      writeback_Reg_In_Execute;
    logic            DUMP;
    logic            md_stall;
    logic [XLEN-1:0] md_result;
    logic            md_result_valid;
    logic [4:0]      md_writeback_Reg;
    logic            md_busy;

    modport master (
        output ALU_Control_In, read_Data_1_In, read_Data_2_In, writeback_Reg_In_Execute, DUMP,
        input  md_stall, md_result, md_result_valid, md_writeback_Reg, md_busy
    );

    modport slave (
        input  ALU_Control_In, read_Data_1_In, read_Data_2_In, writeback_Reg_In_Execute, DUMP,
        output md_stall, md_result, md_result_valid, md_writeback_Reg, md_busy
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage (radix-2, 32 steps).
// Optional build macro MULDIV_EARLY_OUT_EN lets multiplies finish once the multiplier runs out of ones.
module execute_muldiv_unit #(
    parameter int         XLEN     = 32,
    parameter logic [2:0] MD_GROUP = 3'b110
) (
    input logic             clock,
    input logic             reset,
    execute_muldiv_if.slave md_if
);
    localparam logic [1:0]        ST_IDLE   = 2'd0;
    localparam logic [1:0]        ST_RUN    = 2'd1;
    localparam logic [1:0]        ST_DONE   = 2'd2;
    localparam logic [5:0]        LAST_ITER = 6'd31;
    localparam logic [XLEN-1:0]   ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ZERO_W    = {(2*XLEN){1'b0}};

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [5:0]        iter_r;
    logic [2:0]        funct3_r;
    logic [4:0]        wb_reg_r;
    logic [XLEN-1:0]   result_r;
    logic              neg_r;
    logic              rneg_r;
    logic [2*XLEN-1:0] acc_r;
    logic [2*XLEN-1:0] mcand_r;
    logic [XLEN-1:0]   mplier_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   divisor_r;

    logic [2:0]        in_f3_s;
    logic              start_s;
    logic              in_sgn1_op_s;
    logic              in_sgn2_op_s;
    logic              in_sign1_s;
    logic              in_sign2_s;
    logic [XLEN-1:0]   in_mag1_s;
    logic [XLEN-1:0]   in_mag2_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic              special_s;
    logic [XLEN-1:0]   special_val_s;

    logic [2*XLEN-1:0] mul_acc_s;
    logic [2*XLEN-1:0] mcand_sh_s;
    logic [XLEN-1:0]   mplier_sh_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic [XLEN-1:0]   rem_step_s;
    logic [XLEN-1:0]   quo_step_s;
    logic              early_done_s;
    logic              last_step_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_signed_s;
    logic [XLEN-1:0]   rem_signed_s;
    logic [XLEN-1:0]   final_val_s;

    // Decode the instruction waiting on the inputs: start, operand signs/magnitudes, special cases
    always_comb begin
        in_f3_s      = md_if.ALU_Control_In[2:0];
        start_s      = reset && (state_r == ST_IDLE) &&
                       (md_if.ALU_Control_In[5:3] == MD_GROUP) && !md_if.DUMP;
        in_sgn1_op_s = 1'b0;
        in_sgn2_op_s = 1'b0;
        case (in_f3_s)
            3'd1, 3'd4, 3'd6: begin
                in_sgn1_op_s = 1'b1;
                in_sgn2_op_s = 1'b1;
            end
            3'd2: begin
                in_sgn1_op_s = 1'b1;
                in_sgn2_op_s = 1'b0;
            end
            default: begin
                in_sgn1_op_s = 1'b0;
                in_sgn2_op_s = 1'b0;
            end
        endcase
        in_sign1_s = in_sgn1_op_s & md_if.read_Data_1_In[XLEN-1];
        in_sign2_s = in_sgn2_op_s & md_if.read_Data_2_In[XLEN-1];
        in_mag1_s  = in_sign1_s ? (ZERO - md_if.read_Data_1_In) : md_if.read_Data_1_In;
        in_mag2_s  = in_sign2_s ? (ZERO - md_if.read_Data_2_In) : md_if.read_Data_2_In;

        // funct3[2] = divide family, [1] = remainder, [0] = unsigned
        div_zero_s = in_f3_s[2] && (md_if.read_Data_2_In == ZERO);
        div_ovf_s  = in_f3_s[2] && !in_f3_s[0] &&
                     (md_if.read_Data_1_In == INT_MIN) && (md_if.read_Data_2_In == ALL_ONES);
        special_s  = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            special_val_s = in_f3_s[1] ? md_if.read_Data_1_In : ALL_ONES;
        end else if (div_ovf_s) begin
            special_val_s = in_f3_s[1] ? ZERO : INT_MIN;
        end else begin
            special_val_s = ZERO;
        end
    end

    // One radix-2 step of both datapaths plus the signed-corrected final value
    always_comb begin
        mul_acc_s   = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        mcand_sh_s  = {mcand_r[2*XLEN-2:0], 1'b0};
        mplier_sh_s = {1'b0, mplier_r[XLEN-1:1]};

        div_shift_s = {rem_r, quo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, divisor_r};
        if (!div_diff_s[XLEN]) begin
            rem_step_s = div_diff_s[XLEN-1:0];
            quo_step_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_step_s = div_shift_s[XLEN-1:0];
            quo_step_s = {quo_r[XLEN-2:0], 1'b0};
        end

`ifdef MULDIV_EARLY_OUT_EN
        // The multiplicand is shifted, not the accumulator, so stopping early needs no realignment
        early_done_s = !funct3_r[2] && (mplier_sh_s == ZERO);
`else
        early_done_s = 1'b0;
`endif
        last_step_s = (iter_r == LAST_ITER) || early_done_s;

        prod_s       = neg_r ? (ZERO_W - mul_acc_s) : mul_acc_s;
        quo_signed_s = neg_r ? (ZERO - quo_step_s) : quo_step_s;
        rem_signed_s = rneg_r ? (ZERO - rem_step_s) : rem_step_s;
        case (funct3_r)
            3'd0:             final_val_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_val_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_val_s = quo_signed_s;
            default:          final_val_s = rem_signed_s;
        endcase
    end

    // Sequencer next-state; flush beats everything while an operation is in flight
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = special_s ? ST_DONE : ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (md_if.DUMP) begin
                    state_nx_s = ST_IDLE;
                end else if (last_step_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, operand capture, iteration and result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            iter_r    <= 6'd0;
            funct3_r  <= 3'd0;
            wb_reg_r  <= 5'd0;
            result_r  <= ZERO;
            neg_r     <= 1'b0;
            rneg_r    <= 1'b0;
            acc_r     <= ZERO_W;
            mcand_r   <= ZERO_W;
            mplier_r  <= ZERO;
            quo_r     <= ZERO;
            rem_r     <= ZERO;
            divisor_r <= ZERO;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        funct3_r  <= in_f3_s;
                        wb_reg_r  <= md_if.writeback_Reg_In_Execute;
                        iter_r    <= 6'd0;
                        neg_r     <= in_sign1_s ^ in_sign2_s;
                        rneg_r    <= in_sign1_s;
                        acc_r     <= ZERO_W;
                        mcand_r   <= {ZERO, in_mag1_s};
                        mplier_r  <= in_mag2_s;
                        quo_r     <= in_mag1_s;
                        rem_r     <= ZERO;
                        divisor_r <= in_mag2_s;
                        if (special_s) begin
                            result_r <= special_val_s;
                        end
                    end
                end
                ST_RUN: begin
                    if (!md_if.DUMP) begin
                        acc_r    <= mul_acc_s;
                        mcand_r  <= mcand_sh_s;
                        mplier_r <= mplier_sh_s;
                        quo_r    <= quo_step_s;
                        rem_r    <= rem_step_s;
                        iter_r   <= iter_r + 6'd1;
                        if (last_step_s) begin
                            result_r <= final_val_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign md_if.md_stall         = start_s || (state_r == ST_RUN);
    assign md_if.md_result_valid  = (state_r == ST_DONE) && !md_if.DUMP;
    assign md_if.md_busy          = (state_r == ST_RUN);
    assign md_if.md_result        = result_r;
    assign md_if.md_writeback_Reg = wb_reg_r;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed RV32M cases, abort paths and
// random operations checked against a plain-arithmetic reference model.
module tb_execute_muldiv_unit;
    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    execute_muldiv_if md_if ();

    execute_muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .md_if (md_if)
    );

    always #5 clock = ~clock;

    // Architectural result straight from the RISC-V M-extension definition
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin w = {32'd0, a} * {32'd0, b}; ref_md = w[31:0]; end
            3'd1: begin w = sa * sb; ref_md = w[63:32]; end
            3'd2: begin w = sa * longint'({32'd0, b}); ref_md = w[63:32]; end
            3'd3: begin w = {32'd0, a} * {32'd0, b}; ref_md = w[63:32]; end
            3'd4: begin
                if (b == 32'd0) ref_md = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_md = 32'h8000_0000;
                else begin w = sa / sb; ref_md = w[31:0]; end
            end
            3'd5: ref_md = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) ref_md = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_md = 32'd0;
                else begin w = sa % sb; ref_md = w[31:0]; end
            end
            default: ref_md = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the start cycle to the result strobe
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int          steps;
        if (f3[2]) begin
            if (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ref_lat = 1;
            else ref_lat = 33;
        end else begin
`ifdef MULDIV_EARLY_OUT_EN
            m = (f3 == 3'd1 && b[31]) ? (32'd0 - b) : b;
            steps = 1;
            for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
            ref_lat = steps + 1;
`else
            m = b;
            steps = 32;
            ref_lat = steps + 1 + int'(m[0] & 1'b0);
`endif
        end
    endfunction

    // Issue one op in the next IDLE cycle, hold it until the strobe, then drop to a bubble
    task automatic op_run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, output int lat, output logic [31:0] res,
                          output logic [4:0] wb, output int stall_cnt, output logic stall_done);
        @(negedge clock);
        md_if.ALU_Control_In           = {3'b110, f3};
        md_if.read_Data_1_In           = a;
        md_if.read_Data_2_In           = b;
        md_if.writeback_Reg_In_Execute = wd;
        md_if.DUMP                     = 1'b0;
        #1;
        stall_cnt  = md_if.md_stall ? 1 : 0;
        lat        = -1;
        res        = 32'd0;
        wb         = 5'd0;
        stall_done = 1'b1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clock);
            if (md_if.md_result_valid) begin
                lat        = k;
                res        = md_if.md_result;
                wb         = md_if.md_writeback_Reg;
                stall_done = md_if.md_stall;
            end else if (md_if.md_stall) begin
                stall_cnt++;
            end
        end
        md_if.ALU_Control_In = 6'b000_000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        md_if.ALU_Control_In           = 6'b000_000;
        md_if.read_Data_1_In           = 32'd0;
        md_if.read_Data_2_In           = 32'd0;
        md_if.writeback_Reg_In_Execute = 5'd0;
        md_if.DUMP                     = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({md_if.md_stall, md_if.md_result_valid, md_if.md_busy, md_if.md_result, md_if.md_writeback_Reg} !== 40'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got stall=%b valid=%b busy=%b result=%h wb=%0d, want all 0",
                     md_if.md_stall, md_if.md_result_valid, md_if.md_busy, md_if.md_result, md_if.md_writeback_Reg);
        end
        reset = 1'b1;
    endtask

    task automatic test_mul();
        int lat; int sc; logic [31:0] res; logic [4:0] wb; logic sd; int el;
        el = ref_lat(3'd0, 32'd7, 32'd6);
        op_run(3'd0, 32'd7, 32'd6, 5'd5, lat, res, wb, sc, sd);
        n_vec++;
        if (lat !== el) begin n_err++; $display("FAIL mul_latency: got %0d want %0d", lat, el); end
        n_vec++;
        if (res !== 32'd42 || wb !== 5'd5) begin n_err++; $display("FAIL mul_result: got %h/x%0d want 0000002a/x5", res, wb); end
        n_vec++;
        if (sc !== el || sd !== 1'b0) begin n_err++; $display("FAIL mul_stall: got %0d stalled cycles done_stall=%b want %0d/0", sc, sd, el); end
        #1;
        n_vec++;
        if (md_if.md_result_valid !== 1'b1) begin n_err++; $display("FAIL mul_valid_in_done: got %b want 1", md_if.md_result_valid); end
        @(negedge clock);
        n_vec++;
        if (md_if.md_result_valid !== 1'b0 || md_if.md_stall !== 1'b0) begin
            n_err++; $display("FAIL mul_valid_one_cycle: got valid=%b stall=%b want 0/0", md_if.md_result_valid, md_if.md_stall);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [10] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd4, 3'd0};
        logic [31:0] as  [10] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd123, 32'd123, 32'h8000_0000, 32'd5};
        logic [31:0] bs  [10] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] ex  [10] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd123, 32'h8000_0000, 32'd5};
        int lat; int sc; logic [31:0] res; logic [4:0] wb; logic sd;
        for (int i = 0; i < 10; i++) begin
            op_run(f3s[i], as[i], bs[i], 5'(i + 10), lat, res, wb, sc, sd);
            n_vec++;
            if (res !== ex[i] || wb !== 5'(i + 10) || lat !== ref_lat(f3s[i], as[i], bs[i])) begin
                n_err++;
                $display("FAIL directed_%0d: f3=%0d got %h x%0d lat %0d want %h x%0d lat %0d", i, f3s[i], res, wb, lat,
                         ex[i], i + 10, ref_lat(f3s[i], as[i], bs[i]));
            end
        end
    endtask

    task automatic test_dump();
        int lat; int sc; logic [31:0] res; logic [4:0] wb; logic sd; int strobes;
        op_run(3'd5, 32'd100, 32'd7, 5'd3, lat, res, wb, sc, sd);
        @(negedge clock);
        md_if.ALU_Control_In = 6'b110_101;
        md_if.read_Data_1_In = 32'hDEAD_BEEF;
        md_if.read_Data_2_In = 32'd3;
        repeat (10) @(negedge clock);
        md_if.DUMP           = 1'b1;
        md_if.ALU_Control_In = 6'b000_000;
        @(negedge clock);
        md_if.DUMP = 1'b0;
        #1;
        n_vec++;
        if (md_if.md_stall !== 1'b0 || md_if.md_busy !== 1'b0 || md_if.md_result_valid !== 1'b0 || md_if.md_result !== 32'd14) begin
            n_err++;
            $display("FAIL dump_abort: got stall=%b busy=%b valid=%b result=%h want 0/0/0/0000000e",
                     md_if.md_stall, md_if.md_busy, md_if.md_result_valid, md_if.md_result);
        end
        strobes = 0;
        repeat (30) begin @(negedge clock); if (md_if.md_result_valid) strobes++; end
        n_vec++;
        if (strobes !== 0) begin n_err++; $display("FAIL dump_no_strobe: got %0d strobes want 0", strobes); end
        // Flush on the same cycle as a candidate start must win
        md_if.ALU_Control_In = 6'b110_000;
        md_if.DUMP           = 1'b1;
        #1;
        n_vec++;
        if (md_if.md_stall !== 1'b0) begin n_err++; $display("FAIL dump_blocks_start: got stall=%b want 0", md_if.md_stall); end
        @(negedge clock);
        n_vec++;
        if (md_if.md_busy !== 1'b0) begin n_err++; $display("FAIL dump_blocks_busy: got busy=%b want 0", md_if.md_busy); end
        md_if.ALU_Control_In = 6'b000_000;
        md_if.DUMP           = 1'b0;
        // Flush while the one-cycle special result is being presented
        md_if.ALU_Control_In = 6'b110_100;
        md_if.read_Data_1_In = 32'd9;
        md_if.read_Data_2_In = 32'd0;
        @(negedge clock);
        md_if.DUMP           = 1'b1;
        md_if.ALU_Control_In = 6'b000_000;
        #1;
        n_vec++;
        if (md_if.md_result_valid !== 1'b0) begin n_err++; $display("FAIL dump_in_done: got valid=%b want 0", md_if.md_result_valid); end
        @(negedge clock);
        md_if.DUMP = 1'b0;
        #1;
        n_vec++;
        if (md_if.md_result_valid !== 1'b0) begin n_err++; $display("FAIL dump_after_done: got valid=%b want 0", md_if.md_result_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        md_if.ALU_Control_In           = 6'b110_000;
        md_if.read_Data_1_In           = 32'd7;
        md_if.read_Data_2_In           = 32'hFFFF_0000;
        md_if.writeback_Reg_In_Execute = 5'd9;
        repeat (5) @(negedge clock);
        reset                = 1'b0;
        md_if.ALU_Control_In = 6'b000_000;
        @(negedge clock);
        n_vec++;
        if ({md_if.md_stall, md_if.md_result_valid, md_if.md_busy, md_if.md_result, md_if.md_writeback_Reg} !== 40'd0) begin
            n_err++;
            $display("FAIL reset_mid_op: got stall=%b valid=%b busy=%b result=%h wb=%0d want all 0",
                     md_if.md_stall, md_if.md_result_valid, md_if.md_busy, md_if.md_result, md_if.md_writeback_Reg);
        end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat; int sc; logic [31:0] res; logic [4:0] wb; logic sd; int lat2; int el;
        op_run(3'd0, 32'd11, 32'd13, 5'd1, lat, res, wb, sc, sd);
        md_if.ALU_Control_In           = 6'b110_000;
        md_if.read_Data_1_In           = 32'd3;
        md_if.read_Data_2_In           = 32'd1;
        md_if.writeback_Reg_In_Execute = 5'd2;
        #1;
        n_vec++;
        if (res !== 32'd143 || md_if.md_stall !== 1'b0) begin
            n_err++; $display("FAIL b2b_first: got %h stall=%b want 0000008f stall 0", res, md_if.md_stall);
        end
        @(negedge clock);
        n_vec++;
        if (md_if.md_result_valid !== 1'b0 || md_if.md_stall !== 1'b1) begin
            n_err++; $display("FAIL b2b_second_start: got valid=%b stall=%b want 0/1", md_if.md_result_valid, md_if.md_stall);
        end
        lat2 = -1;
        for (int k = 1; k <= 60 && lat2 < 0; k++) begin
            @(negedge clock);
            if (md_if.md_result_valid) begin lat2 = k; res = md_if.md_result; wb = md_if.md_writeback_Reg; end
        end
        md_if.ALU_Control_In = 6'b000_000;
        el = ref_lat(3'd0, 32'd3, 32'd1);
        n_vec++;
        if (lat2 !== el || res !== 32'd3 || wb !== 5'd2) begin
            n_err++; $display("FAIL b2b_second: got lat %0d res %h x%0d want lat %0d res 00000003 x2", lat2, res, wb, el);
        end
    endtask

    task automatic test_random();
        int lat; int sc; logic [31:0] res; logic [4:0] wb; logic sd;
        logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [4:0] wd;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'd1;
                3: b = 32'($urandom_range(0, 255));
                default: b = $urandom;
            endcase
            wd = 5'($urandom_range(0, 31));
            op_run(f3, a, b, wd, lat, res, wb, sc, sd);
            n_vec++;
            if (res !== ref_md(f3, a, b) || wb !== wd || lat !== ref_lat(f3, a, b) || sc !== lat || sd !== 1'b0) begin
                n_err++;
                $display("FAIL random_%0d: f3=%0d a=%h b=%h got %h x%0d lat %0d stalls %0d want %h x%0d lat %0d",
                         i, f3, a, b, res, wb, lat, sc, ref_md(f3, a, b), wd, ref_lat(f3, a, b));
            end
        end
    endtask

    initial begin
        clock = 1'b0;
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mul();
        test_directed();
        test_dump();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
